// File: rtl/ct_lsu_pfu_pmmu_rsp_if.sv
// Bundle between the PFB entry array / MMU prefetch port and the PFU page-translation responder.
// The responder uses the slave modport; the entry array and MMU side use master.
interface ct_lsu_pfu_pmmu_rsp_if #(
    parameter int ENTRY_NUM = 8,
    parameter int VPN_WIDTH = 28,
    parameter int PPN_WIDTH = 28
);
    logic                           pfu_dcache_pref_en;
    logic [ENTRY_NUM-1:0]           entry_mmu_pe_req;
    logic [2*ENTRY_NUM-1:0]         entry_mmu_pe_req_src;
    logic [ENTRY_NUM*VPN_WIDTH-1:0] entry_l1_vpn;
    logic [ENTRY_NUM*VPN_WIDTH-1:0] entry_l2_vpn;
    logic [ENTRY_NUM-1:0]           entry_mmu_pe_req_grnt;
    logic                           pfu_mmu_pe_req_sel_l1;
    logic                           pfu_mmu_req;
    logic [VPN_WIDTH-1:0]           pfu_mmu_req_vpn;
    logic                           mmu_pfu_req_rdy;
    logic                           mmu_pfu_rsp_vld;
    logic [PPN_WIDTH-1:0]           mmu_pfu_rsp_ppn;
    logic                           mmu_pfu_rsp_err;
    logic                           mmu_pfu_rsp_sec;
    logic                           mmu_pfu_rsp_share;
    logic                           pfu_get_ppn_vld;
    logic [PPN_WIDTH-1:0]           pfu_get_ppn;
    logic                           pfu_get_ppn_err;
    logic                           pfu_get_page_sec;
    logic                           pfu_get_page_share;

    modport master (
        output pfu_dcache_pref_en, entry_mmu_pe_req, entry_mmu_pe_req_src,
               entry_l1_vpn, entry_l2_vpn, mmu_pfu_req_rdy, mmu_pfu_rsp_vld,
               mmu_pfu_rsp_ppn, mmu_pfu_rsp_err, mmu_pfu_rsp_sec, mmu_pfu_rsp_share,
        input  entry_mmu_pe_req_grnt, pfu_mmu_pe_req_sel_l1, pfu_mmu_req, pfu_mmu_req_vpn,
               pfu_get_ppn_vld, pfu_get_ppn, pfu_get_ppn_err, pfu_get_page_sec,
               pfu_get_page_share
    );

    modport slave (
        input  pfu_dcache_pref_en, entry_mmu_pe_req, entry_mmu_pe_req_src,
               entry_l1_vpn, entry_l2_vpn, mmu_pfu_req_rdy, mmu_pfu_rsp_vld,
               mmu_pfu_rsp_ppn, mmu_pfu_rsp_err, mmu_pfu_rsp_sec, mmu_pfu_rsp_share,
        output entry_mmu_pe_req_grnt, pfu_mmu_pe_req_sel_l1, pfu_mmu_req, pfu_mmu_req_vpn,
               pfu_get_ppn_vld, pfu_get_ppn, pfu_get_ppn_err, pfu_get_page_sec,
               pfu_get_page_share
    );
endinterface

// File: rtl/ct_lsu_pfu_pmmu_rsp.sv
// PFU page-translation responder: arbitrates PFB entry MMU requests, keeps one translation in flight
// and broadcasts the result. PFU_PMMU_RR_ARB_EN selects round-robin; otherwise lowest index wins.
module ct_lsu_pfu_pmmu_rsp #(
    parameter int ENTRY_NUM = 8,
    parameter int VPN_WIDTH = 28,
    parameter int PPN_WIDTH = 28
) (
    input logic                   forever_cpuclk,
    input logic                   cpurst,
    ct_lsu_pfu_pmmu_rsp_if.slave  pif
);
    localparam int PTR_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

    state_t               state_reg;
    logic                 kill_reg;
    logic [VPN_WIDTH-1:0] vpn_reg;
    logic [PPN_WIDTH-1:0] ppn_reg;
    logic                 err_reg;
    logic                 sec_reg;
    logic                 share_reg;
    logic                 get_vld_reg;

    logic [ENTRY_NUM-1:0] req_valid;
    logic [ENTRY_NUM-1:0] src_l1;
    logic [VPN_WIDTH-1:0] l1_vpn [ENTRY_NUM];
    logic [VPN_WIDTH-1:0] l2_vpn [ENTRY_NUM];

    // A request with neither source bit set carries nothing to translate.
    genvar gi;
    generate
        for (gi = 0; gi < ENTRY_NUM; gi++) begin : g_entry
            assign req_valid[gi] = pif.entry_mmu_pe_req[gi] & (|pif.entry_mmu_pe_req_src[2*gi +: 2]);
            assign src_l1[gi]    = pif.entry_mmu_pe_req_src[2*gi];
            assign l1_vpn[gi]    = pif.entry_l1_vpn[gi*VPN_WIDTH +: VPN_WIDTH];
            assign l2_vpn[gi]    = pif.entry_l2_vpn[gi*VPN_WIDTH +: VPN_WIDTH];
        end
    endgenerate

    logic             any_req;
    logic [PTR_W-1:0] win_idx;

`ifdef PFU_PMMU_RR_ARB_EN
    logic [PTR_W-1:0]       ptr_reg;
    logic [2*ENTRY_NUM-1:0] req_dbl;
    logic [ENTRY_NUM-1:0]   req_rot;
    logic [PTR_W:0]         win_sum;

    // Rotate so the pointer entry sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req_dbl = {req_valid, req_valid} >> ptr_reg;
        req_rot = req_dbl[ENTRY_NUM-1:0];
        any_req = |req_valid;
        win_sum = '0;
        for (int k = ENTRY_NUM - 1; k >= 0; k--) begin
            if (req_rot[k]) win_sum = {1'b0, ptr_reg} + (PTR_W+1)'(k);
        end
        if (win_sum >= (PTR_W+1)'(ENTRY_NUM)) win_sum = win_sum - (PTR_W+1)'(ENTRY_NUM);
        win_idx = win_sum[PTR_W-1:0];
    end
`else
    always_comb begin
        any_req = |req_valid;
        win_idx = '0;
        for (int k = ENTRY_NUM - 1; k >= 0; k--) begin
            if (req_valid[k]) win_idx = PTR_W'(k);
        end
    end
`endif

    logic                 grant_fire;
    logic [VPN_WIDTH-1:0] win_vpn;

    assign grant_fire = (state_reg == IDLE) & pif.pfu_dcache_pref_en & any_req & ~cpurst;
    assign win_vpn    = src_l1[win_idx] ? l1_vpn[win_idx] : l2_vpn[win_idx];

    assign pif.entry_mmu_pe_req_grnt = grant_fire ? (ENTRY_NUM'(1) << win_idx) : '0;
    assign pif.pfu_mmu_pe_req_sel_l1 = grant_fire & src_l1[win_idx];
    assign pif.pfu_mmu_req           = (state_reg == REQ);
    assign pif.pfu_mmu_req_vpn       = vpn_reg;
    assign pif.pfu_get_ppn_vld       = get_vld_reg;
    assign pif.pfu_get_ppn           = ppn_reg;
    assign pif.pfu_get_ppn_err       = err_reg;
    assign pif.pfu_get_page_sec      = sec_reg;
    assign pif.pfu_get_page_share    = share_reg;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_reg   <= IDLE;
            kill_reg    <= 1'b0;
            vpn_reg     <= '0;
            ppn_reg     <= '0;
            err_reg     <= 1'b0;
            sec_reg     <= 1'b0;
            share_reg   <= 1'b0;
            get_vld_reg <= 1'b0;
`ifdef PFU_PMMU_RR_ARB_EN
            ptr_reg     <= '0;
`endif
        end else begin
            get_vld_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_fire) begin
                        vpn_reg   <= win_vpn;
                        state_reg <= REQ;
`ifdef PFU_PMMU_RR_ARB_EN
                        ptr_reg   <= (win_idx == PTR_W'(ENTRY_NUM - 1)) ? '0 : win_idx + 1'b1;
`endif
                    end
                end
                REQ: begin
                    // Once the MMU has accepted, the response must be consumed even if aborted.
                    if (pif.mmu_pfu_req_rdy) begin
                        state_reg <= WAIT;
                        kill_reg  <= ~pif.pfu_dcache_pref_en;
                    end else if (!pif.pfu_dcache_pref_en) begin
                        state_reg <= IDLE;
                    end
                end
                WAIT: begin
                    if (pif.mmu_pfu_rsp_vld) begin
                        ppn_reg     <= pif.mmu_pfu_rsp_ppn;
                        err_reg     <= pif.mmu_pfu_rsp_err;
                        sec_reg     <= pif.mmu_pfu_rsp_sec;
                        share_reg   <= pif.mmu_pfu_rsp_share;
                        get_vld_reg <= ~kill_reg & pif.pfu_dcache_pref_en;
                        kill_reg    <= kill_reg | ~pif.pfu_dcache_pref_en;
                        state_reg   <= RSP;
                    end else if (!pif.pfu_dcache_pref_en) begin
                        kill_reg <= 1'b1;
                    end
                end
                RSP: begin
                    kill_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ct_lsu_pfu_pmmu_rsp.sv
// Directed bench for ct_lsu_pfu_pmmu_rsp: literal checks per scenario plus a per-cycle
// transaction-level reference model compared on every falling edge.
module tb_ct_lsu_pfu_pmmu_rsp;
    localparam int N  = 8;
    localparam int VW = 28;
    localparam int PW = 28;

    logic clk = 1'b0;
    logic cpurst = 1'b1;
    always #5 clk = ~clk;

    ct_lsu_pfu_pmmu_rsp_if #(.ENTRY_NUM(N), .VPN_WIDTH(VW), .PPN_WIDTH(PW)) pif ();

    ct_lsu_pfu_pmmu_rsp #(.ENTRY_NUM(N), .VPN_WIDTH(VW), .PPN_WIDTH(PW)) dut (
        .forever_cpuclk (clk),
        .cpurst         (cpurst),
        .pif            (pif)
    );

    logic [N-1:0]   req;
    logic [2*N-1:0] src;
    logic [VW-1:0]  l1 [N];
    logic [VW-1:0]  l2 [N];
    logic           pref_en, rdy, rsp_vld, rsp_err, rsp_sec, rsp_share;
    logic [PW-1:0]  rsp_ppn;

    assign pif.pfu_dcache_pref_en   = pref_en;
    assign pif.entry_mmu_pe_req     = req;
    assign pif.entry_mmu_pe_req_src = src;
    assign pif.mmu_pfu_req_rdy      = rdy;
    assign pif.mmu_pfu_rsp_vld      = rsp_vld;
    assign pif.mmu_pfu_rsp_ppn      = rsp_ppn;
    assign pif.mmu_pfu_rsp_err      = rsp_err;
    assign pif.mmu_pfu_rsp_sec      = rsp_sec;
    assign pif.mmu_pfu_rsp_share    = rsp_share;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_vpn
            assign pif.entry_l1_vpn[gi*VW +: VW] = l1[gi];
            assign pif.entry_l2_vpn[gi*VW +: VW] = l2[gi];
        end
    endgenerate

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: what the responder owes the entries and the MMU, one cycle at a time.
    bit            m_issuing, m_waiting, m_bphase, m_bvld, m_kill;
    logic [VW-1:0] m_vpn;
    logic [PW-1:0] m_ppn;
    bit            m_err, m_sec, m_share;
    int            m_ptr;

    always @(negedge clk) begin : model
        int  w;
        int  ii;
        bit  g;
        if (chk_en) begin
            g = 1'b0;
            w = 0;
            if (!m_issuing && !m_waiting && !m_bphase && pref_en && !cpurst) begin
                for (int k = 0; k < N; k++) begin
`ifdef PFU_PMMU_RR_ARB_EN
                    ii = (m_ptr + k) % N;
`else
                    ii = k;
`endif
                    if (!g && req[ii] && (src[2*ii] || src[2*ii+1])) begin
                        g = 1'b1;
                        w = ii;
                    end
                end
            end
            check("m_grnt",  64'(pif.entry_mmu_pe_req_grnt), g ? (64'(1) << w) : 64'(0));
            check("m_sel",   64'(pif.pfu_mmu_pe_req_sel_l1), 64'(g && src[2*w]));
            check("m_req",   64'(pif.pfu_mmu_req),           64'(m_issuing));
            check("m_vpn",   64'(pif.pfu_mmu_req_vpn),       64'(m_vpn));
            check("m_vld",   64'(pif.pfu_get_ppn_vld),       64'(m_bvld));
            check("m_ppn",   64'(pif.pfu_get_ppn),           64'(m_ppn));
            check("m_err",   64'(pif.pfu_get_ppn_err),       64'(m_err));
            check("m_sec",   64'(pif.pfu_get_page_sec),      64'(m_sec));
            check("m_share", 64'(pif.pfu_get_page_share),    64'(m_share));

            if (cpurst) begin
                m_issuing = 0; m_waiting = 0; m_bphase = 0; m_bvld = 0; m_kill = 0;
                m_vpn = '0; m_ppn = '0; m_err = 0; m_sec = 0; m_share = 0; m_ptr = 0;
            end else if (g) begin
                m_vpn     = src[2*w] ? l1[w] : l2[w];
                m_issuing = 1;
                m_ptr     = (w + 1) % N;
            end else if (m_issuing) begin
                if (rdy) begin
                    m_issuing = 0;
                    m_waiting = 1;
                    m_kill    = !pref_en;
                end else if (!pref_en) begin
                    m_issuing = 0;
                end
            end else if (m_waiting) begin
                if (rsp_vld) begin
                    m_ppn = rsp_ppn; m_err = rsp_err; m_sec = rsp_sec; m_share = rsp_share;
                    m_waiting = 0;
                    m_bphase  = 1;
                    m_bvld    = !(m_kill || !pref_en);
                end else if (!pref_en) begin
                    m_kill = 1;
                end
            end else if (m_bphase) begin
                m_bphase = 0;
                m_bvld   = 0;
                m_kill   = 0;
            end
        end
    end

    // Caller has driven the requests in the current cycle; runs grant..broadcast, returns in the next IDLE.
    task automatic txn(input string nm, input int idx, input logic sel, input logic [VW-1:0] vpn,
                       input logic [PW-1:0] ppn, input logic e, input logic s, input logic sh,
                       input bit drop);
        #3;
        check({nm, "_grnt"}, 64'(pif.entry_mmu_pe_req_grnt), 64'(1) << idx);
        check({nm, "_sel"},  64'(pif.pfu_mmu_pe_req_sel_l1), 64'(sel));
        step();
        if (drop) req = '0;
        rdy = 1'b1;
        #3;
        check({nm, "_req"}, 64'(pif.pfu_mmu_req),     64'(1));
        check({nm, "_vpn"}, 64'(pif.pfu_mmu_req_vpn), 64'(vpn));
        step();
        rdy = 1'b0;
        rsp_vld = 1'b1; rsp_ppn = ppn; rsp_err = e; rsp_sec = s; rsp_share = sh;
        step();
        rsp_vld = 1'b0;
        #3;
        check({nm, "_vld"},   64'(pif.pfu_get_ppn_vld),    64'(1));
        check({nm, "_ppn"},   64'(pif.pfu_get_ppn),        64'(ppn));
        check({nm, "_err"},   64'(pif.pfu_get_ppn_err),    64'(e));
        check({nm, "_sec"},   64'(pif.pfu_get_page_sec),   64'(s));
        check({nm, "_share"}, 64'(pif.pfu_get_page_share), 64'(sh));
        $display("txn %s: entry=%0d sel_l1=%0d vpn=%07h ppn=%07h err=%0d sec=%0d share=%0d",
                 nm, idx, sel, vpn, ppn, e, s, sh);
        step();
        check({nm, "_vld_drop"}, 64'(pif.pfu_get_ppn_vld), 64'(0));
    endtask

    task automatic do_reset();
        step();
        cpurst = 1'b1;
        step();
        step();
        cpurst = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    int rr_exp [4];

    initial begin : stim
        req = '0; src = '0; pref_en = 1'b1; rdy = 1'b0; rsp_vld = 1'b0;
        rsp_ppn = '0; rsp_err = 1'b0; rsp_sec = 1'b0; rsp_share = 1'b0;
        for (int i = 0; i < N; i++) begin
            l1[i] = '0;
            l2[i] = '0;
        end
        step();
        chk_en = 1'b1;
        step();
        cpurst = 1'b0;
        #3;
        check("rst_grnt", 64'(pif.entry_mmu_pe_req_grnt), 64'(0));
        check("rst_req",  64'(pif.pfu_mmu_req),           64'(0));
        check("rst_vld",  64'(pif.pfu_get_ppn_vld),       64'(0));
        check("rst_ppn",  64'(pif.pfu_get_ppn),           64'(0));
        check("rst_vpn",  64'(pif.pfu_mmu_req_vpn),       64'(0));
        $display("txn reset: outputs idle");

        // Single request from entry 3, L1 source.
        step();
        req[3] = 1'b1; src[7:6] = 2'b01; l1[3] = 28'h0012345;
        txn("single", 3, 1'b1, 28'h0012345, 28'h00ABCDE, 1'b0, 1'b0, 1'b0, 1'b1);

        // Error response with secure attribute, L2 source.
        req[6] = 1'b1; src[13:12] = 2'b10; l2[6] = 28'h0C0C0C0;
        txn("error", 6, 1'b0, 28'h0C0C0C0, 28'h0001234, 1'b1, 1'b1, 1'b0, 1'b1);

        // Entry 1 with both sources: L1 first, then L2 once only L2 remains.
        req[1] = 1'b1; src[3:2] = 2'b11; l1[1] = 28'h00AAAAA; l2[1] = 28'h0BBBBBB;
        txn("src_l1", 1, 1'b1, 28'h00AAAAA, 28'h0011111, 1'b0, 1'b0, 1'b1, 1'b0);
        src[3:2] = 2'b10;
        txn("src_l2", 1, 1'b0, 28'h0BBBBBB, 28'h0022222, 1'b0, 1'b1, 1'b1, 1'b1);

        // Abort while waiting for MMU accept: request withdrawn, no broadcast.
        req[4] = 1'b1; src[9:8] = 2'b01; l1[4] = 28'h0044444;
        #3;
        check("abort_req_grnt", 64'(pif.entry_mmu_pe_req_grnt), 64'h10);
        step();
        req = '0;
        #3;
        check("abort_req_req", 64'(pif.pfu_mmu_req), 64'(1));
        pref_en = 1'b0;
        step();
        #3;
        check("abort_req_drop", 64'(pif.pfu_mmu_req), 64'(0));
        pref_en = 1'b1;
        step();
        step();
        check("abort_req_novld", 64'(pif.pfu_get_ppn_vld), 64'(0));
        $display("txn abort_req: entry=4 request withdrawn");

        // Abort after MMU accept: response consumed, broadcast suppressed.
        req[2] = 1'b1; src[5:4] = 2'b01; l1[2] = 28'h0222222;
        #3;
        check("abort_wait_grnt", 64'(pif.entry_mmu_pe_req_grnt), 64'h04);
        step();
        req = '0; rdy = 1'b1;
        #3;
        check("abort_wait_req", 64'(pif.pfu_mmu_req), 64'(1));
        step();
        rdy = 1'b0; pref_en = 1'b0;
        step();
        pref_en = 1'b1; rsp_vld = 1'b1; rsp_ppn = 28'h0055555;
        step();
        rsp_vld = 1'b0;
        #3;
        check("abort_wait_novld", 64'(pif.pfu_get_ppn_vld), 64'(0));
        step();
        check("abort_wait_idle", 64'(pif.pfu_mmu_req), 64'(0));
        $display("txn abort_wait: entry=2 response consumed silently");
        req[5] = 1'b1; src[11:10] = 2'b01; l1[5] = 28'h0555000;
        txn("post_kill", 5, 1'b1, 28'h0555000, 28'h0066666, 1'b0, 1'b0, 1'b0, 1'b1);

        // Arbitration order with entries 0, 2, 5 held requesting from a fresh pointer.
        do_reset();
`ifdef PFU_PMMU_RR_ARB_EN
        rr_exp = '{0, 2, 5, 0};
`else
        rr_exp = '{0, 0, 0, 0};
`endif
        req = 8'b0010_0101;
        src = '0; src[1:0] = 2'b01; src[5:4] = 2'b01; src[11:10] = 2'b01;
        l1[0] = 28'h0000A00; l1[2] = 28'h0000A02; l1[5] = 28'h0000A05;
        for (int t = 0; t < 4; t++) begin
            txn($sformatf("arb%0d", t), rr_exp[t], 1'b1, l1[rr_exp[t]],
                PW'(28'h0B00000 + t), 1'b0, 1'b0, 1'b0, (t == 3));
        end

        // Back-pressure: request and VPN held while the MMU is not ready, then reset mid-request.
        req[7] = 1'b1; src[15:14] = 2'b01; l1[7] = 28'h0FEDCBA;
        #3;
        check("bp_grnt", 64'(pif.entry_mmu_pe_req_grnt), 64'h80);
        step();
        req = '0;
        for (int c = 0; c < 10; c++) begin
            #3;
            check("bp_req", 64'(pif.pfu_mmu_req),     64'(1));
            check("bp_vpn", 64'(pif.pfu_mmu_req_vpn), 64'h0FEDCBA);
            step();
        end
        cpurst = 1'b1;
        step();
        #3;
        check("rst2_req",  64'(pif.pfu_mmu_req),        64'(0));
        check("rst2_vpn",  64'(pif.pfu_mmu_req_vpn),    64'(0));
        check("rst2_ppn",  64'(pif.pfu_get_ppn),        64'(0));
        check("rst2_vld",  64'(pif.pfu_get_ppn_vld),    64'(0));
        check("rst2_err",  64'(pif.pfu_get_ppn_err),    64'(0));
        $display("txn bp_reset: entry=7 held 10 cycles then reset");
        step();
        cpurst = 1'b0;
        req[5] = 1'b1; src[11:10] = 2'b01; l1[5] = 28'h0505050;
        txn("after_rst", 5, 1'b1, 28'h0505050, 28'h0777777, 1'b0, 1'b1, 1'b1, 1'b1);

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
